tex_column_scheduler: RTL and testbench

- Sequences the texture lookup unit over one screen column at a time.
- Accepts a column descriptor from the DDA stage over a valid/ready handshake.
- Walks rows 0..SCREEN_HEIGHT-1. Each row is classified as ceiling, wall or floor.
- Textured wall rows issue a request to the texture unit and wait for its result. All other rows take flat colours.
- Writes one 16-bit pixel per row into the framebuffer write port, with backpressure.

---
 rtl/tex_column_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_tex_column_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tex_column_scheduler.sv
// tex_column_scheduler
// Walks one screen column row by row, classifying each row as ceiling, wall or
// floor. Textured wall rows fetch a texel from the texture unit; every other
// row uses a flat colour. One 16-bit pixel per row goes to the framebuffer
// write port, which may apply backpressure.
//
// Handshakes:
//   column descriptor: transfer when col_valid_in && col_ready_out at a rising
//     edge of pixel_clk_in. col_ready_out is high only in IDLE.
//   framebuffer write: fb_we_out holds with fb_addr_out/fb_data_out stable
//     until a cycle in which fb_ready_in is high. The write completes there.
//   texture: tex_req_out is a level held through TEX_REQ and TEX_WAIT, and it
//     always drops for at least one cycle (WRITE) between requests so the
//     texture unit can re-arm on its rising edge. tex_valid_in is a one-cycle
//     pulse that is only looked at in TEX_WAIT.
module tex_column_scheduler #(
  parameter int          SCREEN_WIDTH  = 320,
  parameter int          SCREEN_HEIGHT = 180,
  parameter logic [15:0] CEIL_COLOR    = 16'h18C3,
  parameter logic [15:0] FLOOR_COLOR   = 16'h4208,
  parameter logic [15:0] FLAT_COLOR    = 16'hFFFF,
  parameter logic [15:0] ERR_COLOR     = 16'hF81F,
  parameter int          TIMEOUT       = 64
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  // column descriptor from the DDA stage
  input  logic        col_valid_in,
  output logic        col_ready_out,
  input  logic [8:0]  col_hcount_in,
  input  logic [7:0]  col_lineheight_in,
  input  logic [15:0] col_wallx_in,
  input  logic [3:0]  col_map_in,
  // texture unit interface
  output logic        tex_req_out,
  output logic [15:0] tex_wallx_out,
  output logic [7:0]  tex_lineheight_out,
  output logic [9:0]  tex_drawstart_out,
  output logic [7:0]  tex_vcount_out,
  output logic [3:0]  tex_sel_out,
  input  logic [15:0] tex_pixel_in,
  input  logic        tex_valid_in,
  // framebuffer write port
  output logic        fb_we_out,
  output logic [15:0] fb_addr_out,
  output logic [15:0] fb_data_out,
  input  logic        fb_ready_in,
  // status
  output logic        col_done_out,
  output logic        tex_timeout_out,
  output logic [2:0]  dbg_state_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECIDE   = 3'd1,
    TEX_REQ  = 3'd2,
    TEX_WAIT = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Wide enough to hold TIMEOUT-1 even for tiny TIMEOUT values.
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]        ROW_LAST = 8'(SCREEN_HEIGHT - 1);
  localparam logic [9:0]        HALF_H   = 10'(SCREEN_HEIGHT >> 1);

  state_t                state;
  logic [7:0]            row;
  logic [8:0]            hcount_q;
  logic signed [10:0]    drawend_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic [9:0]            ds_calc;
  logic signed [10:0]    de_calc;
  logic [10:0]           row_ext;
  logic                  above_wall;
  logic                  below_wall;
  logic                  textured;
  logic [15:0]           addr_calc;

  assign dbg_state_out = state;

  // Wall extent for the incoming descriptor, row classification for the
  // current row, and the framebuffer address of the current row.
  always_comb begin
    ds_calc    = HALF_H - {3'b000, col_lineheight_in[7:1]};
    de_calc    = {ds_calc[9], ds_calc} + {3'b000, col_lineheight_in};
    row_ext    = {3'b000, row};
    above_wall = $signed(row_ext) < $signed({tex_drawstart_out[9], tex_drawstart_out});
    below_wall = $signed(row_ext) >= drawend_q;
    textured   = (tex_sel_out == 4'd3) || (tex_sel_out == 4'd4) || (tex_sel_out == 4'd5);
    addr_calc  = 16'(32'(row) * SCREEN_WIDTH + 32'(hcount_q));
  end

  // Column sequencer: all outputs are registered here.
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      row                <= '0;
      hcount_q           <= '0;
      drawend_q          <= '0;
      wait_cnt           <= '0;
      col_ready_out      <= 1'b1;
      tex_req_out        <= 1'b0;
      tex_wallx_out      <= '0;
      tex_lineheight_out <= '0;
      tex_drawstart_out  <= '0;
      tex_vcount_out     <= '0;
      tex_sel_out        <= '0;
      fb_we_out          <= 1'b0;
      fb_addr_out        <= '0;
      fb_data_out        <= '0;
      col_done_out       <= 1'b0;
      tex_timeout_out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (col_valid_in && col_ready_out) begin
            hcount_q           <= col_hcount_in;
            tex_wallx_out      <= col_wallx_in;
            tex_lineheight_out <= col_lineheight_in;
            tex_sel_out        <= col_map_in;
            tex_drawstart_out  <= ds_calc;
            drawend_q          <= de_calc;
            row                <= '0;
            col_ready_out      <= 1'b0;
            state              <= DECIDE;
          end
        end

        DECIDE: begin
          fb_addr_out <= addr_calc;
          if (above_wall) begin
            fb_data_out <= CEIL_COLOR;
            fb_we_out   <= 1'b1;
            state       <= WRITE;
          end else if (below_wall) begin
            fb_data_out <= FLOOR_COLOR;
            fb_we_out   <= 1'b1;
            state       <= WRITE;
          end else if (textured) begin
            tex_req_out    <= 1'b1;
            tex_vcount_out <= row;
            state          <= TEX_REQ;
          end else begin
            fb_data_out <= FLAT_COLOR;
            fb_we_out   <= 1'b1;
            state       <= WRITE;
          end
        end

        TEX_REQ: begin
          wait_cnt <= '0;
          state    <= TEX_WAIT;
        end

        TEX_WAIT: begin
          // A texel arriving on the last allowed cycle still wins over the
          // timeout.
          if (tex_valid_in) begin
            fb_data_out <= tex_pixel_in;
            tex_req_out <= 1'b0;
            fb_we_out   <= 1'b1;
            state       <= WRITE;
          end else if (wait_cnt == CNT_LAST) begin
            fb_data_out     <= ERR_COLOR;
            tex_timeout_out <= 1'b1;
            tex_req_out     <= 1'b0;
            fb_we_out       <= 1'b1;
            state           <= WRITE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WRITE: begin
          if (fb_ready_in) begin
            fb_we_out <= 1'b0;
            if (row == ROW_LAST) begin
              col_done_out <= 1'b1;
              state        <= DONE;
            end else begin
              row   <= row + 1'b1;
              state <= DECIDE;
            end
          end
        end

        DONE: begin
          col_done_out  <= 1'b0;
          col_ready_out <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          fb_we_out     <= 1'b0;
          tex_req_out   <= 1'b0;
          col_done_out  <= 1'b0;
          col_ready_out <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tex_column_scheduler.sv
// Directed bench for tex_column_scheduler: ceiling/floor-only, flat wall,
// textured wall, full-height wall, texture timeout, framebuffer stall and
// reset in the middle of a column.
module tb_tex_column_scheduler;

  localparam logic [15:0] CEIL_C  = 16'h18C3;
  localparam logic [15:0] FLOOR_C = 16'h4208;
  localparam logic [15:0] FLAT_C  = 16'hFFFF;
  localparam logic [15:0] ERR_C   = 16'hF81F;

  // ---------------- clock / reset ----------------
  logic pixel_clk_in = 1'b0;
  initial forever #5 pixel_clk_in = ~pixel_clk_in;

  logic        rst_n_in = 1'b0;
  logic        col_valid_in = 1'b0;
  logic        col_ready_out;
  logic [8:0]  col_hcount_in = '0;
  logic [7:0]  col_lineheight_in = '0;
  logic [15:0] col_wallx_in = '0;
  logic [3:0]  col_map_in = '0;
  logic        tex_req_out;
  logic [15:0] tex_wallx_out;
  logic [7:0]  tex_lineheight_out;
  logic [9:0]  tex_drawstart_out;
  logic [7:0]  tex_vcount_out;
  logic [3:0]  tex_sel_out;
  logic [15:0] tex_pixel_in = '0;
  logic        tex_valid_in = 1'b0;
  logic        fb_we_out;
  logic [15:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        fb_ready_in = 1'b1;
  logic        col_done_out;
  logic        tex_timeout_out;
  logic [2:0]  dbg_state_out;

  tex_column_scheduler dut (
    .pixel_clk_in      (pixel_clk_in),
    .rst_n_in          (rst_n_in),
    .col_valid_in      (col_valid_in),
    .col_ready_out     (col_ready_out),
    .col_hcount_in     (col_hcount_in),
    .col_lineheight_in (col_lineheight_in),
    .col_wallx_in      (col_wallx_in),
    .col_map_in        (col_map_in),
    .tex_req_out       (tex_req_out),
    .tex_wallx_out     (tex_wallx_out),
    .tex_lineheight_out(tex_lineheight_out),
    .tex_drawstart_out (tex_drawstart_out),
    .tex_vcount_out    (tex_vcount_out),
    .tex_sel_out       (tex_sel_out),
    .tex_pixel_in      (tex_pixel_in),
    .tex_valid_in      (tex_valid_in),
    .fb_we_out         (fb_we_out),
    .fb_addr_out       (fb_addr_out),
    .fb_data_out       (fb_data_out),
    .fb_ready_in       (fb_ready_in),
    .col_done_out      (col_done_out),
    .tex_timeout_out   (tex_timeout_out),
    .dbg_state_out     (dbg_state_out)
  );

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          accept_cyc = 0;
  int          done_cyc = 0;
  int          last_wr_cyc = 0;
  logic [15:0] last_wr_addr = '0;
  int          wr_count = 0;
  int          stray_wr = 0;
  bit          done_flag = 1'b0;
  int          req_rises = 0;
  int          gap_viol = 0;
  int          exp_vrow = 0;
  bit          tex_respond = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge pixel_clk_in);
    cyc++;
  end

  // ---------------- scoreboard monitor (negedge sampling) ----------------
  initial forever begin
    @(negedge pixel_clk_in);
    if (fb_we_out && fb_ready_in) begin
      wr_count++;
      last_wr_cyc  = cyc;
      last_wr_addr = fb_addr_out;
      if (exp_q.size() == 0) stray_wr++;
      else check("fb_write {addr,data}", {fb_addr_out, fb_data_out}, exp_q.pop_front());
    end
    if (fb_we_out && tex_req_out) gap_viol++;
    if (col_done_out) begin
      done_flag = 1'b1;
      done_cyc  = cyc;
    end
  end

  // ---------------- texture unit model: 3-cycle latency ----------------
  initial begin
    logic        prev_req;
    logic [15:0] pix;
    prev_req = 1'b0;
    forever begin
      @(posedge pixel_clk_in); #1;
      if (tex_req_out && !prev_req) begin
        req_rises++;
        check("tex_vcount_at_req", 32'(tex_vcount_out), 32'(exp_vrow));
        exp_vrow++;
        if (tex_respond) begin
          pix = 16'h1000 + {8'h00, tex_vcount_out};
          repeat (3) @(posedge pixel_clk_in);
          #1;
          tex_pixel_in = pix;
          tex_valid_in = 1'b1;
          @(posedge pixel_clk_in); #1;
          tex_valid_in = 1'b0;
          tex_pixel_in = 16'hDEAD;
        end
      end
      prev_req = tex_req_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_col(input int hc, input int lh, input int map, input bit no_tex);
    int ds, de;
    logic [15:0] pix, addr;
    ds = 90 - lh / 2;
    de = ds + lh;
    for (int r = 0; r < 180; r++) begin
      if (r < ds)                       pix = CEIL_C;
      else if (r >= de)                 pix = FLOOR_C;
      else if (map >= 3 && map <= 5)    pix = no_tex ? ERR_C : 16'(32'h1000 + r);
      else                              pix = FLAT_C;
      addr = 16'(r * 320 + hc);
      exp_q.push_back({addr, pix});
    end
  endtask

  task automatic start_col(input int hc, input int lh, input int map, input logic [15:0] wx,
                           input logic [9:0] exp_ds);
    int guard = 0;
    while (!col_ready_out && guard < 1000) begin
      @(posedge pixel_clk_in); #1;
      guard++;
    end
    check("col_ready_before_accept", 32'(col_ready_out), 32'd1);
    col_hcount_in     = 9'(hc);
    col_lineheight_in = 8'(lh);
    col_map_in        = 4'(map);
    col_wallx_in      = wx;
    col_valid_in      = 1'b1;
    done_flag         = 1'b0;
    accept_cyc        = cyc;
    @(posedge pixel_clk_in); #1;
    col_valid_in      = 1'b0;
    col_wallx_in      = 16'h0;
    col_map_in        = 4'h0;
    check("col_ready_after_accept", 32'(col_ready_out), 32'd0);
    check("tex_drawstart", 32'(tex_drawstart_out), 32'(exp_ds));
    check("tex_fields {wallx,lh,sel}", {4'h0, tex_wallx_out, tex_lineheight_out, tex_sel_out},
          {4'h0, wx, 8'(lh), 4'(map)});
  endtask

  task automatic wait_done(input int exp_cycles);
    int guard = 0;
    while (!done_flag && guard < 20000) begin
      @(posedge pixel_clk_in); #1;
      guard++;
    end
    check("col_done_seen", 32'(done_flag), 32'd1);
    check("column_cycles", 32'(done_cyc - accept_cyc + 1), 32'(exp_cycles));
    check("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("expected_writes_left", 32'(exp_q.size()), 32'd0);
    check("stray_writes", 32'(stray_wr), 32'd0);
    @(posedge pixel_clk_in); #1;
    check("ready_after_done", {30'd0, col_ready_out, col_done_out}, 32'd2);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready_we_done_req_to", {27'd0, col_ready_out, fb_we_out, col_done_out,
          tex_req_out, tex_timeout_out}, 32'h10);
    check("rst_fb_addr_data", {fb_addr_out, fb_data_out}, 32'h0);
    check("rst_tex_wallx_lh_vcount", {tex_wallx_out, tex_lineheight_out, tex_vcount_out}, 32'h0);
    check("rst_tex_ds_sel_state", {15'd0, tex_drawstart_out, tex_sel_out, dbg_state_out}, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard, wr_snap;

    rst_n_in = 1'b0;
    repeat (3) @(posedge pixel_clk_in);
    #1;
    check_reset_outputs();
    rst_n_in = 1'b1;
    @(posedge pixel_clk_in); #1;

    // 1: lineheight 0 -> ceiling above row 90, floor from row 90
    push_col(5, 0, 3, 1'b0);
    req_rises = 0;
    start_col(5, 0, 3, 16'h1234, 10'd90);
    wait_done(362);
    check("t1_tex_req_rises", 32'(req_rises), 32'd0);
    check("t1_last_addr", 32'(last_wr_addr), 32'd57285);

    // 2: flat wall rows 80..99
    push_col(0, 20, 1, 1'b0);
    req_rises = 0;
    start_col(0, 20, 1, 16'h0ABC, 10'd80);
    wait_done(362);
    check("t2_tex_req_rises", 32'(req_rises), 32'd0);

    // 3: textured wall rows 80..99, 3-cycle texture latency
    push_col(7, 20, 4, 1'b0);
    req_rises = 0; gap_viol = 0; exp_vrow = 80;
    start_col(7, 20, 4, 16'h8001, 10'd80);
    wait_done(160 * 2 + 20 * 6 + 2);
    check("t3_tex_req_rises", 32'(req_rises), 32'd20);
    check("t3_req_during_write", 32'(gap_viol), 32'd0);

    // 4: wall taller than the screen -> every row textured
    push_col(319, 200, 5, 1'b0);
    req_rises = 0; gap_viol = 0; exp_vrow = 0;
    start_col(319, 200, 5, 16'hFFFE, 10'h3F6);
    wait_done(180 * 6 + 2);
    check("t4_tex_req_rises", 32'(req_rises), 32'd180);
    check("t4_req_during_write", 32'(gap_viol), 32'd0);
    check("t4_last_addr", 32'(last_wr_addr), 32'd57599);

    // 5: texture unit never answers -> ERR_COLOR after 64 wait cycles
    check("t5_timeout_flag_before", 32'(tex_timeout_out), 32'd0);
    tex_respond = 1'b0;
    push_col(1, 4, 3, 1'b1);
    req_rises = 0; exp_vrow = 88;
    start_col(1, 4, 3, 16'h0040, 10'd88);
    wait_done(1 + 176 * 2 + 4 * (3 + 64) + 1);
    check("t5_tex_req_rises", 32'(req_rises), 32'd4);
    check("t5_timeout_flag_after", 32'(tex_timeout_out), 32'd1);
    tex_respond = 1'b1;

    // 6a: framebuffer stalls 5 cycles on row 3
    push_col(2, 20, 1, 1'b0);
    start_col(2, 20, 1, 16'h0002, 10'd80);
    guard = 0;
    while (!(fb_we_out && fb_addr_out == 16'(3 * 320 + 2)) && guard < 100) begin
      @(posedge pixel_clk_in); #1;
      guard++;
    end
    check("t6_row3_write_seen", {15'd0, fb_we_out, fb_addr_out}, {15'd0, 1'b1, 16'(3 * 320 + 2)});
    fb_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge pixel_clk_in); #1;
      check("t6_stall_hold {addr,data}", {fb_addr_out, fb_data_out}, {16'(3 * 320 + 2), CEIL_C});
      check("t6_stall_we", 32'(fb_we_out), 32'd1);
    end
    fb_ready_in = 1'b1;
    wait_done(362 + 5);
    check("t6_timeout_sticky", 32'(tex_timeout_out), 32'd1);

    // 6b: reset while row 90 is being written
    push_col(3, 20, 1, 1'b0);
    start_col(3, 20, 1, 16'h0003, 10'd80);
    guard = 0;
    while (!(fb_we_out && fb_addr_out == 16'(90 * 320 + 3)) && guard < 1000) begin
      @(posedge pixel_clk_in); #1;
      guard++;
    end
    check("t6_row90_write_seen", {15'd0, fb_we_out, fb_addr_out}, {15'd0, 1'b1, 16'(90 * 320 + 3)});
    rst_n_in    = 1'b0;
    fb_ready_in = 1'b0;
    @(posedge pixel_clk_in); #1;
    check_reset_outputs();
    check("t6_abandoned_rows", 32'(exp_q.size()), 32'd90);
    exp_q.delete();
    wr_snap = wr_count;
    @(posedge pixel_clk_in); #1;
    rst_n_in    = 1'b1;
    fb_ready_in = 1'b1;
    repeat (400) @(posedge pixel_clk_in);
    #1;
    check("t6_no_writes_after_reset", 32'(wr_count), 32'(wr_snap));
    check("t6_stray_writes", 32'(stray_wr), 32'd0);
    check("t6_idle_ready", {29'd0, col_ready_out, dbg_state_out[1:0]}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
